// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared types and constants for the configuration loader.
//   cfg_state_t : loader FSM states
//   CRC8_POLY / CRC8_INIT : CRC-8 parameters for the optional trailer check
//   crc8_bit() : one MSB-first CRC-8 update step
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BYTE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_CRC_WAIT,
      ST_DONE
   } cfg_state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
      return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC8_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// fpga_cfg_loader_if: valid/ready byte stream feeding the loader.
//   byte_valid : upstream byte available
//   byte_data  : configuration byte, MSB shifted first
//   byte_ready : loader accepts a byte this cycle
// master = byte source, slave = loader.
interface fpga_cfg_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;

   modport master (output byte_valid, output byte_data, input byte_ready);
   modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/fpga_cfg_pclk_gen.sv
// fpga_cfg_pclk_gen: prog_clk phase timer.
//   clk, rst_n : system clock, async active-low reset
//   run        : a shift phase is in progress (counter held at 0 otherwise)
//   phase_end  : high on the last clk cycle of each PCLK_DIV-cycle phase
module fpga_cfg_pclk_gen #(
   parameter int unsigned PCLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic phase_end
);

   localparam int unsigned DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

   logic [DIV_W-1:0] cnt;

   assign phase_end = run && (cnt == DIV_W'(PCLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!run || phase_end)
         cnt <= '0;
      else
         cnt <= cnt + DIV_W'(1);
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: serialises configuration bytes MSB-first onto ccff_head,
// one bit per prog_clk rising edge, for exactly CHAIN_LEN bits.
//   clk, rst_n  : system clock, async active-low reset
//   start       : begin a load from IDLE or DONE (ignored while busy)
//   byte_if     : valid/ready byte input (slave modport)
//   prog_clk    : registered configuration shift clock
//   ccff_head   : serial data to chain head; changes only while prog_clk=0
//   ccff_tail   : serial data from chain tail, sampled late in each high phase
//   busy, done  : load in progress / load complete (held until next start)
//   bit_count   : bits shifted in the current load
//   tail_byte   : last 8 ccff_tail samples, newest in bit 0
//   crc_ok      : trailer CRC match (CFG_CRC_EN) or simply done otherwise
// Optional feature macro: CFG_CRC_EN (CRC-8 over shifted bits plus trailer byte).
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 1024,
   parameter int unsigned PCLK_DIV  = 4,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   fpga_cfg_loader_if.slave    byte_if,
   output logic                prog_clk,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    bit_count,
   output logic [7:0]          tail_byte,
   output logic                crc_ok
);

   cfg_state_t state, next_state;
   logic [6:0] rest;        // bits of the current byte still to follow ccff_head
   logic [2:0] bit_idx;
   logic       byte_ready;
   logic       phase_end;
   logic       start_load;
   logic       hi_end;
   logic       last_bit;
   logic       xfer;

   fpga_cfg_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       ((state == ST_SHIFT_LO) || (state == ST_SHIFT_HI)),
      .phase_end (phase_end)
   );

   assign start_load = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign hi_end     = (state == ST_SHIFT_HI) && phase_end;
   assign last_bit   = (bit_count == CNT_W'(CHAIN_LEN - 1));
   assign xfer       = (state == ST_WAIT_BYTE) && byte_if.byte_valid;
   assign busy       = (state != ST_IDLE) && (state != ST_DONE);
   assign done       = (state == ST_DONE);
   assign byte_if.byte_ready = byte_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      byte_ready = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start)
               next_state = ST_WAIT_BYTE;
         end
         ST_WAIT_BYTE: begin
            byte_ready = 1'b1;
            if (byte_if.byte_valid)
               next_state = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            if (phase_end)
               next_state = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            // Chain length wins over byte boundary: a partial last byte is dropped.
            if (phase_end) begin
               if (last_bit)
`ifdef CFG_CRC_EN
                  next_state = ST_CRC_WAIT;
`else
                  next_state = ST_DONE;
`endif
               else if (bit_idx == 3'd7)
                  next_state = ST_WAIT_BYTE;
               else
                  next_state = ST_SHIFT_LO;
            end
         end
`ifdef CFG_CRC_EN
         ST_CRC_WAIT: begin
            byte_ready = 1'b1;
            if (byte_if.byte_valid)
               next_state = ST_DONE;
         end
`endif
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_clk  <= 1'b0;
         ccff_head <= 1'b0;
         rest      <= '0;
         bit_idx   <= '0;
         bit_count <= '0;
         tail_byte <= '0;
      end else begin
         // High exactly while the FSM sits in SHIFT_HI, from a flop.
         prog_clk <= (next_state == ST_SHIFT_HI);
         if (start_load) begin
            bit_count <= '0;
            tail_byte <= '0;
         end
         if (xfer) begin
            ccff_head <= byte_if.byte_data[7];
            rest      <= byte_if.byte_data[6:0];
            bit_idx   <= '0;
         end
         if (hi_end) begin
            tail_byte <= {tail_byte[6:0], ccff_tail};
            bit_count <= bit_count + CNT_W'(1);
            bit_idx   <= bit_idx + 3'd1;
            rest      <= {rest[5:0], 1'b0};
            if (next_state == ST_SHIFT_LO)
               ccff_head <= rest[6];
         end
      end
   end

`ifdef CFG_CRC_EN
   logic [7:0] crc;
   logic       crc_ok_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc      <= CRC8_INIT;
         crc_ok_q <= 1'b0;
      end else begin
         if (start_load) begin
            crc      <= CRC8_INIT;
            crc_ok_q <= 1'b0;
         end
         if (hi_end)
            crc <= crc8_bit(crc, ccff_head);
         if ((state == ST_CRC_WAIT) && byte_if.byte_valid)
            crc_ok_q <= (byte_if.byte_data == crc);
      end
   end

   assign crc_ok = crc_ok_q;
`else
   assign crc_ok = done;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: randomized self-checking bench for fpga_cfg_loader.
// Two loaders share clk/rst_n: inst0 (CHAIN_LEN=16, PCLK_DIV=2) and
// inst1 (CHAIN_LEN=12, PCLK_DIV=1, partial final byte). Each drives a
// behavioural chain model whose ccff_tail is the bit pushed out of the chain.
// Expectations come from a stream model (bit history, polynomial-division CRC).
// Honours CFG_CRC_EN for the trailer byte and crc_ok expectation.
module tb_fpga_cfg_loader;

   localparam int L0 = 16;
   localparam int D0 = 2;
   localparam int L1 = 12;
   localparam int D1 = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       chain_clr = 1'b1;
   logic [1:0] start = '0;
   logic [1:0] valid = '0;
   logic [7:0] data [2] = '{8'h00, 8'h00};

   wire [1:0] pclk, head, busy, done, crc_ok, rdy, tail;
   wire [4:0] bc0;
   wire [3:0] bc1;
   wire [7:0] tb0, tb1;

   logic [L0-1:0] chain0;
   logic [L1-1:0] chain1;
   logic          tq0, tq1;

   int n_tests = 0;
   int n_fail  = 0;

   int          edges    [2] = '{0, 0};
   int          acc      [2] = '{0, 0};
   int          bad_len  [2] = '{0, 0};
   int          head_bad [2] = '{0, 0};
   int          hi_run   [2] = '{0, 0};
   logic [1:0]  prev_p = '0;
   logic [1:0]  prev_h = '0;
   logic [63:0] got_bits [2] = '{64'd0, 64'd0};

   logic       hist [2][1024];
   int         hist_n [2] = '{0, 0};
   logic [7:0] bq [$];

   always #5 clk = ~clk;

   fpga_cfg_loader_if bif0 ();
   fpga_cfg_loader_if bif1 ();

   assign bif0.byte_valid = valid[0];
   assign bif0.byte_data  = data[0];
   assign bif1.byte_valid = valid[1];
   assign bif1.byte_data  = data[1];
   assign rdy  = {bif1.byte_ready, bif0.byte_ready};
   assign tail = {tq1, tq0};

   fpga_cfg_loader #(.CHAIN_LEN(L0), .PCLK_DIV(D0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .byte_if(bif0),
      .prog_clk(pclk[0]), .ccff_head(head[0]), .ccff_tail(tail[0]),
      .busy(busy[0]), .done(done[0]), .bit_count(bc0), .tail_byte(tb0),
      .crc_ok(crc_ok[0])
   );

   fpga_cfg_loader #(.CHAIN_LEN(L1), .PCLK_DIV(D1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .byte_if(bif1),
      .prog_clk(pclk[1]), .ccff_head(head[1]), .ccff_tail(tail[1]),
      .busy(busy[1]), .done(done[1]), .bit_count(bc1), .tail_byte(tb1),
      .crc_ok(crc_ok[1])
   );

   // Fabric chains: shift on prog_clk rise, tail shows the bit pushed out.
   always @(posedge pclk[0] or posedge chain_clr)
      if (chain_clr) {tq0, chain0} <= '0;
      else           {tq0, chain0} <= {chain0, head[0]};

   always @(posedge pclk[1] or posedge chain_clr)
      if (chain_clr) {tq1, chain1} <= '0;
      else           {tq1, chain1} <= {chain1, head[1]};

   function automatic int len_of(input int k);
      return (k == 0) ? L0 : L1;
   endfunction

   function automatic int div_of(input int k);
      return (k == 0) ? D0 : D1;
   endfunction

   function automatic logic [63:0] bcnt_of(input int k);
      return (k == 0) ? 64'(bc0) : 64'(bc1);
   endfunction

   function automatic logic [63:0] tail_of(input int k);
      return (k == 0) ? 64'(tb0) : 64'(tb1);
   endfunction

   // Remainder of msg(x)*x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] crc_ref(input logic [63:0] msg, input int n);
      logic [71:0] v;
      v = {msg, 8'h00};
      for (int i = n + 7; i >= 8; i--)
         if (v[i]) v = v ^ (72'h107 << (i - 8));
      return v[7:0];
   endfunction

   // Edge, high-length, head-stability and handshake monitor.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            hi_run[k] <= 0;
            prev_p[k] <= 1'b0;
         end else begin
            if (pclk[k]) begin
               hi_run[k] <= hi_run[k] + 1;
               if (!prev_p[k]) begin
                  edges[k]    <= edges[k] + 1;
                  got_bits[k] <= {got_bits[k][62:0], head[k]};
               end else if (head[k] !== prev_h[k]) begin
                  head_bad[k] <= head_bad[k] + 1;
               end
            end else begin
               if (hi_run[k] != 0 && hi_run[k] != div_of(k))
                  bad_len[k] <= bad_len[k] + 1;
               hi_run[k] <= 0;
            end
            if (valid[k] && rdy[k])
               acc[k] <= acc[k] + 1;
            prev_p[k] <= pclk[k];
            prev_h[k] <= head[k];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input int k);
      check($sformatf("inst%0d rst prog_clk", k),  64'(pclk[k]),   64'd0);
      check($sformatf("inst%0d rst ccff_head", k), 64'(head[k]),   64'd0);
      check($sformatf("inst%0d rst busy", k),      64'(busy[k]),   64'd0);
      check($sformatf("inst%0d rst done", k),      64'(done[k]),   64'd0);
      check($sformatf("inst%0d rst byte_ready", k), 64'(rdy[k]),   64'd0);
      check($sformatf("inst%0d rst bit_count", k), bcnt_of(k),     64'd0);
      check($sformatf("inst%0d rst tail_byte", k), tail_of(k),     64'd0);
      check($sformatf("inst%0d rst crc_ok", k),    64'(crc_ok[k]), 64'd0);
   endtask

   task automatic pulse_start(input int k);
      start[k] = 1'b1;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
   endtask

   task automatic feed(input int k, input logic [7:0] b);
      bit taken;
      taken = 1'b0;
      valid[k] = 1'b1;
      data[k]  = b;
      for (int c = 0; c < 400 && !taken; c++) begin
         @(negedge clk);
         if (rdy[k]) begin
            @(posedge clk);
            #1;
            taken = 1'b1;
         end
      end
      valid[k] = 1'b0;
      if (!taken) check($sformatf("inst%0d feed_timeout", k), 64'd0, 64'd1);
   endtask

   task automatic wait_done(input int k);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         seen = done[k];
      end
      #1;
      check($sformatf("inst%0d done", k), 64'(done[k]), 64'd1);
   endtask

   // One full load of the bytes in bq on instance k.
   task automatic run_load(input int k, input int stall, input bit mid_start);
      int          len, nb, n0, e0, a0, b0, h0, exp_acc;
      logic [63:0] exp_bits, mask;
      logic [7:0]  exp_tail, exp_crc, trail;
      logic        exp_ok;
      len      = len_of(k);
      nb       = (len + 7) / 8;
      exp_bits = '0;
      mask     = (64'd1 << len) - 64'd1;
      n0       = hist_n[k];
      for (int i = 0; i < len; i++) begin
         logic [7:0] by;
         by = bq[i / 8];
         exp_bits = {exp_bits[62:0], by[7 - (i % 8)]};
         hist[k][n0 + i] = by[7 - (i % 8)];
      end
      hist_n[k] = n0 + len;
      exp_tail = '0;
      for (int j = 0; j < 8; j++) begin
         int n;
         n = n0 + len - 7 + j;
         exp_tail = {exp_tail[6:0], (n - 1 >= len) ? hist[k][n - 1 - len] : 1'b0};
      end
      exp_crc = crc_ref(exp_bits, len);
`ifdef CFG_CRC_EN
      exp_ok  = 1'($urandom_range(0, 1));
      trail   = exp_ok ? exp_crc : (exp_crc ^ 8'(1 << $urandom_range(0, 7)));
      exp_acc = nb + 1;
`else
      exp_ok  = 1'b1;
      trail   = exp_crc;
      exp_acc = nb;
`endif
      e0 = edges[k];
      a0 = acc[k];
      b0 = bad_len[k];
      h0 = head_bad[k];
      pulse_start(k);
      for (int i = 0; i < nb; i++) begin
         if (i == 1 && stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check($sformatf("inst%0d stall edges", k), 64'(edges[k] - e0), 64'd8);
            check($sformatf("inst%0d stall prog_clk", k), 64'(pclk[k]), 64'd0);
            check($sformatf("inst%0d stall bit_count", k), bcnt_of(k), 64'd8);
         end else begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         feed(k, bq[i]);
         if (i == 0 && mid_start) pulse_start(k);
      end
`ifdef CFG_CRC_EN
      feed(k, trail);
`else
      valid[k] = 1'b1;
      data[k]  = 8'hEE;
`endif
      wait_done(k);
      valid[k] = 1'b0;
      check($sformatf("inst%0d edges", k),     64'(edges[k] - e0), 64'(len));
      check($sformatf("inst%0d head bits", k), got_bits[k] & mask, exp_bits);
      check($sformatf("inst%0d bit_count", k), bcnt_of(k), 64'(len));
      check($sformatf("inst%0d busy", k),      64'(busy[k]), 64'd0);
      check($sformatf("inst%0d tail_byte", k), tail_of(k), 64'(exp_tail));
      check($sformatf("inst%0d crc_ok", k),    64'(crc_ok[k]), 64'(exp_ok));
      check($sformatf("inst%0d bytes taken", k), 64'(acc[k] - a0), 64'(exp_acc));
      check($sformatf("inst%0d high length", k), 64'(bad_len[k] - b0), 64'd0);
      check($sformatf("inst%0d head stable", k), 64'(head_bad[k] - h0), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bit hi;
      repeat (3) @(posedge clk);
      #1;
      check_reset(0);
      check_reset(1);
      rst_n     = 1'b1;
      chain_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      bq = '{8'hA5, 8'h3C};  run_load(0, 0, 1'b0);
      bq = '{8'hFF, 8'hA0};  run_load(1, 0, 1'b0);
      bq = '{8'h12, 8'h34};  run_load(0, 0, 1'b0);
      bq = '{8'hAB, 8'hCD};  run_load(0, 0, 1'b0);
      bq = '{8'h5E, 8'hC1};  run_load(0, 50, 1'b0);
      bq = '{8'h96, 8'h7B};  run_load(1, 50, 1'b0);
      bq = '{8'h0F, 8'hF0};  run_load(0, 0, 1'b1);

      for (int it = 0; it < 8; it++) begin
         int k;
         k  = $urandom_range(0, 1);
         bq = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
         run_load(k, ($urandom_range(0, 3) == 0) ? 50 : 0, 1'($urandom_range(0, 1)));
      end

      // Abort in the middle of a prog_clk high phase.
      pulse_start(0);
      feed(0, 8'hC3);
      hi = 1'b0;
      for (int c = 0; c < 200 && !hi; c++) begin
         @(negedge clk);
         hi = pclk[0];
      end
      check("inst0 abort reached high phase", 64'(hi), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset(0);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      chain_clr = 1'b1;
      #1;
      chain_clr = 1'b0;
      hist_n    = '{0, 0};
      repeat (2) @(posedge clk);
      #1;
      bq = '{8'h81, 8'h7E};  run_load(0, 0, 1'b0);
      bq = '{8'h3C, 8'h55};  run_load(1, 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
